// File: rtl/gray_code_converter_pipe.sv
// Two-stage pipelined bidirectional binary/Gray converter with valid/ready handshake.
// Stage 1 captures the request; stage 2 converts it and drives the output directly from flops.
module gray_code_converter_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
);

  localparam logic MODE_B2G = 1'b0;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s1_mode;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;
  logic             r_s2_mode;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_b2g;
  logic [WIDTH-1:0] w_g2b;
  logic [WIDTH-1:0] w_conv;

  // Advance conditions: a stage may load when it is empty or its consumer is draining it.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = rst_n && w_s1_adv;
  assign w_in_fire = in_valid && w_s1_adv;

  // Binary to Gray: each bit XORed with its upper neighbour, MSB passes through.
  assign w_b2g = r_s1_data ^ (r_s1_data >> 1);

  // Gray to binary: each bit is the XOR of all Gray bits at and above it.
  always_comb begin
    w_g2b = r_s1_data;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      w_g2b = w_g2b ^ (r_s1_data >> i);
    end
  end

  // Select conversion direction from the captured mode bit.
  assign w_conv = (r_s1_mode == MODE_B2G) ? w_b2g : w_g2b;

  // Stage 1: capture request on input fire; no arithmetic here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_data <= in_data;
        r_s1_mode <= in_mode;
      end
    end
  end

  // Stage 2: register converted result; data only moves when stage 1 holds a valid item.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_mode  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_conv;
        r_s2_mode <= r_s1_mode;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_mode  = r_s2_mode;

endmodule

// File: tb/tb_gray_code_converter_pipe.sv
// Scoreboard bench for gray_code_converter_pipe: directed WIDTH=8 tests plus random WIDTH=2/64 streams.
module tb_gray_code_converter_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_mode;

  int n_checks;
  int n_err;

  typedef struct {
    logic [63:0] data;
    logic        mode;
    int          step;
  } exp_t;

  exp_t       sb[$];
  int         step_no;
  int         n_out;
  bit         chk_lat;
  bit         chk_adj;
  bit         have_prev;
  logic [7:0] prev_g;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gray_code_converter_pipe #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model written bit by bit from the conversion definitions.
  function automatic logic [63:0] m_b2g(input logic [63:0] b, input int w);
    logic [63:0] g;
    g = '0;
    for (int i = 0; i < w; i++) begin
      if (i == w - 1) g[i] = b[i];
      else            g[i] = b[i+1] ^ b[i];
    end
    return g;
  endfunction

  function automatic logic [63:0] m_g2b(input logic [63:0] g, input int w);
    logic [63:0] b;
    logic        x;
    b = '0;
    for (int i = 0; i < w; i++) begin
      x = 1'b0;
      for (int j = i; j < w; j++) x = x ^ g[j];
      b[i] = x;
    end
    return b;
  endfunction

  function automatic logic [7:0] m8(input logic [7:0] d, input logic m);
    return m ? 8'(m_g2b(64'(d), 8)) : 8'(m_b2g(64'(d), 8));
  endfunction

  task automatic pop_check();
    exp_t e;
    n_out++;
    chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("data", 64'(out_data), e.data);
      chk("mode", 64'(out_mode), 64'(e.mode));
      if (chk_lat) chk("latency", 64'(step_no - e.step), 64'd2);
      if (chk_adj) begin
        if (have_prev) chk("gray_1bit", 64'($countones(out_data ^ prev_g)), 64'd1);
        prev_g    = out_data;
        have_prev = 1'b1;
      end
    end
  endtask

  // One cycle: drive at the falling edge, settle, predict transfers at the next rising edge.
  task automatic step(input logic iv, input logic [7:0] d, input logic m,
                      input logic [7:0] e, input logic ordy, output logic fired);
    in_valid  = iv;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    #1;
    fired = iv && in_ready;
    if (fired) sb.push_back('{64'(e), m, step_no});
    if (out_valid && out_ready) pop_check();
    @(negedge clk);
    step_no++;
  endtask

  task automatic send(input logic [7:0] d, input logic m, input logic [7:0] e, input logic ordy);
    logic f;
    int   n;
    n = 0;
    do begin
      step(1'b1, d, m, e, ordy, f);
      n++;
    end while (!f && n < 50);
    chk("send_fired", 64'(f), 64'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic f;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, ordy, f);
  endtask

  // Directed sequence on the 8-bit instance.
  initial begin
    logic       f;
    logic [7:0] d;
    logic       m;
    int         n0;
    n_checks = 0; n_err = 0; step_no = 0; n_out = 0;
    chk_lat = 1'b0; chk_adj = 1'b0; have_prev = 1'b0; prev_g = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;

    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_mode", 64'(out_mode), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Basic conversions with latency check
    chk_lat = 1'b1;
    send(8'h2D, 1'b0, 8'h3B, 1'b1);
    idle(3, 1'b1);
    send(8'h3B, 1'b1, 8'h2D, 1'b1);
    idle(3, 1'b1);

    // Boundary values
    send(8'hFF, 1'b0, 8'h80, 1'b1);
    send(8'h80, 1'b1, 8'hFF, 1'b1);
    send(8'h00, 1'b0, 8'h00, 1'b1);
    send(8'h00, 1'b1, 8'h00, 1'b1);
    idle(3, 1'b1);

    // Exhaustive: Gray codes of consecutive values differ in one bit, and every value round-trips
    chk_adj = 1'b1; have_prev = 1'b0;
    for (int v = 0; v < 256; v++) send(8'(v), 1'b0, m8(8'(v), 1'b0), 1'b1);
    idle(3, 1'b1);
    chk_adj = 1'b0;
    for (int v = 0; v < 256; v++) send(m8(8'(v), 1'b0), 1'b1, 8'(v), 1'b1);
    idle(3, 1'b1);

    // Back-to-back stream with alternating modes
    n0 = n_out;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      m = 1'(i % 2);
      step(1'b1, d, m, m8(d, m), 1'b1, f);
      chk("stream_in_ready", 64'(f), 64'd1);
    end
    idle(3, 1'b1);
    chk("stream_count", 64'(n_out - n0), 64'd10);
    chk_lat = 1'b0;

    // Backpressure: two accepted, third stalls, output held
    n0 = n_out;
    step(1'b1, 8'h5A, 1'b0, m8(8'h5A, 1'b0), 1'b0, f);
    chk("bp_acc_a", 64'(f), 64'd1);
    step(1'b1, 8'hC3, 1'b1, m8(8'hC3, 1'b1), 1'b0, f);
    chk("bp_acc_b", 64'(f), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h71, 1'b0, m8(8'h71, 1'b0), 1'b0, f);
      chk("bp_stall", 64'(f), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", 64'(out_data), 64'(m8(8'h5A, 1'b0)));
      chk("bp_hold_mode", 64'(out_mode), 64'd0);
    end
    step(1'b1, 8'h71, 1'b0, m8(8'h71, 1'b0), 1'b1, f);
    chk("bp_release_acc", 64'(f), 64'd1);
    idle(5, 1'b1);
    chk("bp_count", 64'(n_out - n0), 64'd3);

    // Reset with both stages full discards everything
    step(1'b1, 8'hA5, 1'b0, m8(8'hA5, 1'b0), 1'b0, f);
    step(1'b1, 8'h3C, 1'b1, m8(8'h3C, 1'b1), 1'b0, f);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    sb.delete();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    n0 = n_out;
    idle(6, 1'b1);
    chk("no_stale_out", 64'(n_out - n0), 64'd0);
    chk_lat = 1'b1;
    send(8'h2D, 1'b0, 8'h3B, 1'b1);
    idle(4, 1'b1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Wait for the random width streams
    for (int i = 0; i < 80000 && !(g_rnd[0].done && g_rnd[1].done); i++) @(negedge clk);
    chk("rnd_done", 64'(g_rnd[0].done && g_rnd[1].done), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Random streams with random backpressure at the extreme widths.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
    localparam int unsigned W    = (gi == 0) ? 2 : 64;
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

    logic         rn;
    logic         iv;
    logic         ir;
    logic [W-1:0] id;
    logic         im;
    logic         ov;
    logic         ordy;
    logic [W-1:0] od;
    logic         om;
    logic         done;
    logic [63:0]  q_d[$];
    logic         q_m[$];

    gray_code_converter_pipe #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rn),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_data   (id),
      .in_mode   (im),
      .out_valid (ov),
      .out_ready (ordy),
      .out_data  (od),
      .out_mode  (om)
    );

    initial begin
      int          sent;
      int          cyc;
      logic [63:0] d;
      logic [63:0] e;
      logic        m;
      sent = 0; cyc = 0;
      done = 1'b0; rn = 1'b0; iv = 1'b0; id = '0; im = 1'b0; ordy = 1'b0;
      repeat (2) @(negedge clk);
      rn = 1'b1;
      while ((sent < 10000 || q_d.size() != 0) && cyc < 60000) begin
        if (sent == 0 && W == 64) begin
          d = 64'h8000_0000_0000_0000;
          m = 1'b1;
          e = 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
          d = {$urandom, $urandom} & MASK;
          m = 1'($urandom_range(0, 1));
          e = m ? m_g2b(d, W) : m_b2g(d, W);
        end
        iv   = (sent < 10000) && ($urandom_range(0, 3) != 0);
        id   = W'(d);
        im   = m;
        ordy = ($urandom_range(0, 3) != 0);
        #1;
        if (iv && ir) begin
          q_d.push_back(e);
          q_m.push_back(m);
          sent++;
        end
        if (ov && ordy) begin
          chk($sformatf("w%0d_sb_nonempty", W), 64'(q_d.size() > 0), 64'd1);
          if (q_d.size() > 0) begin
            chk($sformatf("w%0d_data", W), 64'(od), q_d.pop_front());
            chk($sformatf("w%0d_mode", W), 64'(om), 64'(q_m.pop_front()));
          end
        end
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("w%0d_complete", W), 64'(sent == 10000 && q_d.size() == 0), 64'd1);
      done = 1'b1;
    end
  end

endmodule

// File: doc/gray_code_converter_pipe.md
Name: gray_code_converter_pipe

Overview:
Parametrised, pipelined bidirectional Gray-code converter. It is the successor to the fixed 4-bit combinational binary-to-Gray block. Each transaction carries a mode bit selecting binary-to-Gray or Gray-to-binary. Two registered stages sit behind a valid/ready handshake with full backpressure. It is intended for clock-domain pointer paths and encoder interfaces that need arbitrary widths.

Parameters:
WIDTH, 8, data width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept input this cycle
in_data  input  WIDTH  value to convert
in_mode  input  1  0 = binary->Gray, 1 = Gray->binary
out_valid  output  1  output transaction valid
out_ready  input  1  downstream accepts output this cycle
out_data  output  WIDTH  converted value
out_mode  output  1  mode the value was converted with (echo of in_mode)

Behaviour:
- Interface: one clock (clk); reset synchronous, active-low (rst_n).
- Reset (rst_n=0 at a clk edge):
  - s1_valid, s2_valid, out_valid go to 0.
  - out_data and out_mode go to 0.
  - in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
  - Reset mid-transaction discards all in-flight data. No output is produced for it.
- Transfers: input fires when in_valid && in_ready. Output fires when out_valid && out_ready.
- Stage 1 (S1) registers in_data and in_mode on input fire. It holds no arithmetic.
- Stage 2 (S2) computes from S1 and registers the result. out_data, out_mode and out_valid come directly from S2 flops.
- Arithmetic, bit i in 0..WIDTH-1:
  - binary->Gray: g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i+1] ^ b[i].
  - Gray->binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i], which is the XOR of g[WIDTH-1:i].
  - No truncation or extension; output width always equals WIDTH.
- Pipeline advance:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready and state; no path from in_valid).
  - On s2_adv: s2_valid <= s1_valid, and S2 data loads when s1_valid=1.
  - On s1_adv: s1_valid <= in_valid, and S1 data loads on fire.
- Latency: exactly 2 cycles from input fire to out_valid=1 when out_ready stays high.
- Throughput: 1 transaction per cycle when out_ready stays high.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_mode hold stable.
  - With S1 also full, in_ready=0. At most 2 transactions are in flight.
- Simultaneous output fire and input fire with both stages full: both stages shift in the same cycle and no bubble is inserted.
- Ordering: strict FIFO order, and modes may be mixed back-to-back.
- in_data and in_mode are ignored when in_valid=0 or in_ready=0.
- No X propagation from idle inputs: S2 data changes only when S1 holds valid data.

Test Plan (WIDTH=8 unless noted):
1. Reset, then send in_data=0x2D, mode=0, out_ready=1 -> exactly 2 cycles later out_valid=1, out_data=0x3B, out_mode=0. Then send 0x3B with mode=1 -> out_data=0x2D.
2. Boundaries:
   - 0xFF mode 0 -> 0x80.
   - 0x80 mode 1 -> 0xFF.
   - 0x00 either mode -> 0x00.
   - Exhaustive 0..255: every value round-trips; consecutive binary inputs give Gray outputs differing in exactly 1 bit.
3. Stream 10 back-to-back transactions with alternating modes and out_ready=1 -> in_ready stays 1, 10 outputs on consecutive cycles in order, first at cycle 2.
4. Hold out_ready=0 and send 3 items -> 2 accepted, then in_ready=0 and out_data held stable. Raise out_ready -> remaining item accepted in that cycle and all 3 delivered in order with no loss or duplication.
5. Deassert rst_n for 1 cycle with both stages full -> out_valid=0 and out_data=0 the next cycle, in_ready=1 after release, and no stale output appears afterwards.
6. WIDTH=2 and WIDTH=64:
   - Random 10k transactions with random out_ready compared against a reference model.
   - WIDTH=64 case: 0x8000_0000_0000_0000 mode 1 -> 0xFFFF_FFFF_FFFF_FFFF.
